// File: rtl/sort_pkg.sv
// Shared types and default sizing for the serial descending key sorter.
// The optional arrival-index path is enabled with SORT_PERM_EN.
package sort_pkg;

  localparam int unsigned SORT_N  = 4;
  localparam int unsigned SORT_W  = 4;
  localparam int unsigned SORT_IW = $clog2(SORT_N);
  localparam int unsigned SORT_CW = $clog2(SORT_N + 1);

  typedef logic [SORT_W-1:0]  key_t;
  typedef logic [SORT_IW-1:0] idx_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/sort_slot.sv
// One storage cell of the insertion sorter: holds an entry {key[, idx]} and
// decides locally whether to hold, take the new entry, or shift.
module sort_slot #(
  parameter int unsigned W  = 4,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] upper_i,
  input  logic [DW-1:0] lower_i,
  input  logic [DW-1:0] in_i,
  input  logic          upper_lt_i,
  input  logic          active_i,
  input  logic          tail_i,
  input  logic          insert_i,
  input  logic          pop_i,
  output logic [DW-1:0] slot_o,
  output logic          lt_c_o
);

  logic [DW-1:0] slot_q;
  logic [DW-1:0] slot_d;

  // Strict compare keeps equal keys ahead of the newcomer (stable order).
  assign lt_c_o = active_i && (slot_q[DW-1 -: W] < in_i[DW-1 -: W]);
  assign slot_o = slot_q;

  always_comb begin
    slot_d = slot_q;
    if (insert_i) begin
      if (upper_lt_i) begin
        slot_d = upper_i;
      end else if (lt_c_o || tail_i) begin
        slot_d = in_i;
      end
    end else if (pop_i) begin
      slot_d = lower_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/stream_sort4.sv
// Serial insertion sorter: collects up to N keys, re-emits them largest first.
// Define SORT_PERM_EN to carry each key's arrival index on out_idx.
module stream_sort4
  import sort_pkg::*;
#(
  parameter  int unsigned N  = SORT_N,
  parameter  int unsigned W  = SORT_W,
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last
`ifdef SORT_PERM_EN
  ,
  output logic [IW-1:0] out_idx
`endif
);

`ifdef SORT_PERM_EN
  localparam int unsigned DW = W + IW;
`else
  localparam int unsigned DW = W;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          insert;
  logic          pop;
  logic [DW-1:0] in_entry;
  logic [DW-1:0] slot_q [N];
  logic          lt     [N];

`ifdef SORT_PERM_EN
  assign in_entry = {in_data, IW'(count_q)};
`else
  assign in_entry = in_data;
`endif

  // Slot array: slot 0 is the largest key; neighbours feed the shift paths.
  for (genvar k = 0; k < N; k++) begin : g_slot
    logic [DW-1:0] up_e;
    logic [DW-1:0] lo_e;
    logic          up_lt;

    if (k == 0) begin : g_head
      assign up_e  = '0;
      assign up_lt = 1'b0;
    end else begin : g_body
      assign up_e  = slot_q[k-1];
      assign up_lt = lt[k-1];
    end

    if (k == N - 1) begin : g_tail
      assign lo_e = '0;
    end else begin : g_rest
      assign lo_e = slot_q[k+1];
    end

    sort_slot #(
      .W  (W),
      .DW (DW)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .upper_i    (up_e),
      .lower_i    (lo_e),
      .in_i       (in_entry),
      .upper_lt_i (up_lt),
      .active_i   (CW'(k) < count_q),
      .tail_i     (CW'(k) == count_q),
      .insert_i   (insert),
      .pop_i      (pop),
      .slot_o     (slot_q[k]),
      .lt_c_o     (lt[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Frame closes on in_last or when the N-th key is accepted.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    insert  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          insert  = 1'b1;
          count_d = count_q + CW'(1);
          if (in_last || (count_q == CW'(N - 1))) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pop     = 1'b1;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = FILL;
          end
        end
      end
      default: begin
        state_d = FILL;
        count_d = '0;
      end
    endcase
  end

  // Outputs decode straight from the state, count and slot-0 flops.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? slot_q[0][DW-1 -: W] : '0;
  assign out_last  = out_valid && (count_q == CW'(1));

`ifdef SORT_PERM_EN
  assign out_idx = out_valid ? slot_q[0][IW-1:0] : '0;
`endif

endmodule
